// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the segment scan decoder.
// Holds the ten 7-segment digit codes (segments a..g on bits 0..6), the
// all-off blank code, the value reported for an undecodable pattern and a
// helper that counts how many digit selects are active in one sample.
package seg_scan_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] DIGIT_ERR = 4'hE;

   // Number of active digit selects in a 4-bit select sample.
   function automatic logic [2:0] sel_count(input logic [3:0] sel);
      sel_count = {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder.
// Ports:
//   pattern  in  7  segments a..g on bits 0..6 (active high)
//   value    out 4  decoded digit; 0 for blank, DIGIT_ERR when undecodable
//   blank    out 1  pattern was all-off
//   invalid  out 1  pattern is neither a digit code nor blank
module seg7_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] value,
   output logic       blank,
   output logic       invalid
);

   always_comb begin
      value   = 4'd0;
      blank   = 1'b0;
      invalid = 1'b0;
      case (pattern)
         SEG_0:     value = 4'd0;
         SEG_1:     value = 4'd1;
         SEG_2:     value = 4'd2;
         SEG_3:     value = 4'd3;
         SEG_4:     value = 4'd4;
         SEG_5:     value = 4'd5;
         SEG_6:     value = 4'd6;
         SEG_7:     value = 4'd7;
         SEG_8:     value = 4'd8;
         SEG_9:     value = 4'd9;
         SEG_BLANK: blank = 1'b1;
         default: begin
            value   = DIGIT_ERR;
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/segment_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit 7-segment display bus.
// Samples the scanned select/segment/dot lines, waits for each digit slot to
// settle, decodes it and assembles four digits into a frame that is published
// with a one-cycle frame_valid pulse.
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   segment_in[6:0]   segments a..g;  dot_in  decimal point
//   byte_in[3:0]      digit selects, bit n = digit n
//   err_clear         pulse clearing collision_err
//   digits_out[15:0]  digit n on [4n+3:4n] (4'hE = undecodable)
//   blank_out[3:0]    digit n was all-off;  dot_out[3:0]  captured dots
//   frame_valid       one-cycle pulse when the published outputs update
//   decode_err        frame contained an undecodable digit
//   collision_err     sticky: more than one select seen active
//   stale             no commit for 2^TIMEOUT_W-1 cycles
//
// Handshake: frame_valid is a pure strobe with no back-pressure; the published
// outputs change only on the cycle frame_valid is high and hold otherwise.
module segment_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int SETTLE          = 4,
   parameter int TIMEOUT_W       = 16,
   parameter bit SEL_ACTIVE_HIGH = 1'b1,
   parameter bit SEG_ACTIVE_HIGH = 1'b1
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  segment_in,
   input  logic        dot_in,
   input  logic [3:0]  byte_in,
   input  logic        err_clear,
   output logic [15:0] digits_out,
   output logic [3:0]  blank_out,
   output logic [3:0]  dot_out,
   output logic        frame_valid,
   output logic        decode_err,
   output logic        collision_err,
   output logic        stale
);

   logic [3:0]           sel_fix, sel_q, sel_prev;
   logic [6:0]           seg_fix, seg_q, seg_prev;
   logic                 dot_fix, dot_q, dot_prev;
   logic [3:0]           settle_cnt, cnt_now;
   logic                 committed, committed_next;
   logic [3:0]           captured, cap_next;
   logic [15:0]          stage_digits;
   logic [3:0]           stage_blank, stage_dot, stage_inv, inv_next;
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic [2:0]           n_sel;
   logic                 one_sel, coll, same, commit, frame_done, wd_max;
   logic [3:0]           dec_value;
   logic                 dec_blank, dec_invalid;

   // Polarity is normalised before the single input register stage.
   assign sel_fix = SEL_ACTIVE_HIGH ? byte_in : ~byte_in;
   assign seg_fix = SEG_ACTIVE_HIGH ? segment_in : ~segment_in;
   assign dot_fix = SEG_ACTIVE_HIGH ? dot_in : ~dot_in;

   seg7_decode u_decode (
      .pattern (seg_q),
      .value   (dec_value),
      .blank   (dec_blank),
      .invalid (dec_invalid)
   );

   always_comb begin
      n_sel      = sel_count(sel_q);
      one_sel    = (n_sel == 3'd1);
      coll       = (n_sel > 3'd1);
      same       = ({sel_q, seg_q, dot_q} == {sel_prev, seg_prev, dot_prev});
      frame_done = (captured == 4'hF);
      wd_max     = &wd_cnt;

      // Run length of the current sample; idle and collision slots never settle.
      if (one_sel && same)
         cnt_now = (settle_cnt == 4'hF) ? 4'hF : settle_cnt + 4'd1;
      else
         cnt_now = 4'd0;

      // Any change of select or pattern re-arms the commit.
      commit         = one_sel && !(same && committed) && (cnt_now == 4'(SETTLE - 1));
      committed_next = one_sel && ((same && committed) || commit);

      cap_next = captured;
      inv_next = stage_inv;
      if (frame_done || (wd_max && !commit)) begin
         cap_next = 4'd0;
         inv_next = 4'd0;
      end
      if (commit) begin
         cap_next = cap_next | sel_q;
         inv_next = (inv_next & ~sel_q) | (dec_invalid ? sel_q : 4'd0);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_q      <= '0;
         seg_q      <= '0;
         dot_q      <= 1'b0;
         sel_prev   <= '0;
         seg_prev   <= '0;
         dot_prev   <= 1'b0;
         settle_cnt <= '0;
         committed  <= 1'b0;
      end else begin
         sel_q      <= sel_fix;
         seg_q      <= seg_fix;
         dot_q      <= dot_fix;
         sel_prev   <= sel_q;
         seg_prev   <= seg_q;
         dot_prev   <= dot_q;
         settle_cnt <= cnt_now;
         committed  <= committed_next;
      end
   end

   // Staging registers, capture mask and no-commit watchdog.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         captured     <= '0;
         stage_inv    <= '0;
         stage_digits <= '0;
         stage_blank  <= '0;
         stage_dot    <= '0;
         wd_cnt       <= '0;
      end else begin
         captured  <= cap_next;
         stage_inv <= inv_next;
         for (int i = 0; i < 4; i++) begin
            if (commit && sel_q[i]) begin
               stage_digits[4*i +: 4] <= dec_value;
               stage_blank[i]         <= dec_blank;
               stage_dot[i]           <= dot_q;
            end
         end
         if (commit)
            wd_cnt <= '0;
         else if (!wd_max)
            wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Published outputs and status flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digits_out    <= '0;
         blank_out     <= '0;
         dot_out       <= '0;
         frame_valid   <= 1'b0;
         decode_err    <= 1'b0;
         collision_err <= 1'b0;
         stale         <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         if (frame_done) begin
            digits_out <= stage_digits;
            blank_out  <= stage_blank;
            dot_out    <= stage_dot;
            decode_err <= |stage_inv;
            stale      <= 1'b0;
         end else if (wd_max) begin
            stale <= 1'b1;
         end
         // A collision in the same cycle as err_clear keeps the flag set.
         if (coll)
            collision_err <= 1'b1;
         else if (err_clear)
            collision_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Self-checking bench for segment_scan_decoder: directed scenarios plus
// randomized frames checked against a table-driven display model.
module tb_segment_scan_decoder;

   localparam int SETTLE = 4;
   localparam int TW     = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  segment_in;
   logic        dot_in;
   logic [3:0]  byte_in;
   logic        err_clear;
   logic [15:0] digits_out;
   logic [3:0]  blank_out;
   logic [3:0]  dot_out;
   logic        frame_valid;
   logic        decode_err;
   logic        collision_err;
   logic        stale;

   int checks = 0;
   int errors = 0;

   // frames seen by the monitor and their contents
   int          frame_cnt = 0;
   logic [15:0] f_digits;
   logic [3:0]  f_blank;
   logic [3:0]  f_dot;
   logic        f_err;

   logic [15:0] exp_q[$];

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always #5 clock = ~clock;

   segment_scan_decoder #(
      .SETTLE          (SETTLE),
      .TIMEOUT_W       (TW),
      .SEL_ACTIVE_HIGH (1'b1),
      .SEG_ACTIVE_HIGH (1'b1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .segment_in    (segment_in),
      .dot_in        (dot_in),
      .byte_in       (byte_in),
      .err_clear     (err_clear),
      .digits_out    (digits_out),
      .blank_out     (blank_out),
      .dot_out       (dot_out),
      .frame_valid   (frame_valid),
      .decode_err    (decode_err),
      .collision_err (collision_err),
      .stale         (stale)
   );

   always @(negedge clock) begin
      if (frame_valid === 1'b1) begin
         frame_cnt++;
         f_digits = digits_out;
         f_blank  = blank_out;
         f_dot    = dot_out;
         f_err    = decode_err;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [3:0] ref_val(input logic [6:0] p);
      ref_val = 4'hE;
      if (p == 7'h00) ref_val = 4'h0;
      for (int k = 0; k < 10; k++)
         if (seg_tab[k] == p) ref_val = 4'(k);
   endfunction

   function automatic logic [6:0] rand_pat();
      int r;
      logic [6:0] p;
      r = $urandom_range(0, 9);
      if (r < 7) begin
         p = seg_tab[$urandom_range(0, 9)];
      end else if (r < 8) begin
         p = 7'h00;
      end else begin
         p = 7'($urandom);
         while (p == 7'h00 || ref_val(p) != 4'hE) p = 7'($urandom);
      end
      return p;
   endfunction

   // ---------------- drivers ----------------
   task automatic hold(input logic [3:0] sel, input logic [6:0] pat, input logic d, input int n);
      byte_in    = sel;
      segment_in = pat;
      dot_in     = d;
      repeat (n) @(negedge clock);
   endtask

   task automatic scan(input int n, input logic [6:0] pat, input logic d, input int hold_n, input int gap_n);
      logic [3:0] s;
      s = 4'b0001 << n;
      hold(s, pat, d, hold_n);
      hold(4'b0000, 7'h00, 1'b0, gap_n);
   endtask

   task automatic wait_frame(input int start, input int budget);
      int n = 0;
      while (frame_cnt == start && n < budget) begin
         @(negedge clock);
         n++;
      end
      repeat (2) @(negedge clock);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; byte_in = 4'd0; segment_in = 7'd0; dot_in = 1'b0; err_clear = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (digits_out !== 16'h0) begin errors++; $display("FAIL reset_digits got %h exp 0000", digits_out); end
      checks++; if (blank_out !== 4'h0) begin errors++; $display("FAIL reset_blank got %h exp 0", blank_out); end
      checks++; if (dot_out !== 4'h0) begin errors++; $display("FAIL reset_dot got %h exp 0", dot_out); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", frame_valid); end
      checks++; if (decode_err !== 1'b0) begin errors++; $display("FAIL reset_decode_err got %b exp 0", decode_err); end
      checks++; if (collision_err !== 1'b0) begin errors++; $display("FAIL reset_collision got %b exp 0", collision_err); end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL reset_stale got %b exp 0", stale); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_basic();
      int start = frame_cnt;
      for (int k = 0; k < 4; k++) scan(k, seg_tab[k+1], 1'b0, 8, 2);
      wait_frame(start, 20);
      checks++; if (frame_cnt != start + 1) begin errors++; $display("FAIL basic_count got %0d exp %0d", frame_cnt - start, 1); end
      checks++; if (f_digits !== 16'h4321) begin errors++; $display("FAIL basic_digits got %h exp 4321", f_digits); end
      checks++; if (f_blank !== 4'h0) begin errors++; $display("FAIL basic_blank got %h exp 0", f_blank); end
      checks++; if (f_err !== 1'b0) begin errors++; $display("FAIL basic_decode_err got %b exp 0", f_err); end
      checks++; if (f_dot !== 4'h0) begin errors++; $display("FAIL basic_dot got %h exp 0", f_dot); end
   endtask

   task automatic test_short_settle();
      int start = frame_cnt;
      scan(2, seg_tab[7], 1'b0, SETTLE - 1, 1);
      scan(0, seg_tab[5], 1'b1, 6, 1);
      scan(1, seg_tab[6], 1'b0, 6, 1);
      scan(3, seg_tab[8], 1'b0, 6, 1);
      repeat (2) @(negedge clock);
      checks++; if (frame_cnt != start) begin errors++; $display("FAIL short_no_frame got %0d exp 0", frame_cnt - start); end
      scan(2, seg_tab[9], 1'b0, 6, 1);
      wait_frame(start, 20);
      checks++; if (frame_cnt != start + 1) begin errors++; $display("FAIL short_count got %0d exp 1", frame_cnt - start); end
      checks++; if (f_digits !== 16'h8965) begin errors++; $display("FAIL short_digits got %h exp 8965", f_digits); end
      checks++; if (f_dot !== 4'b0001) begin errors++; $display("FAIL short_dot got %b exp 0001", f_dot); end
   endtask

   task automatic test_invalid();
      int start = frame_cnt;
      scan(0, seg_tab[0], 1'b0, 6, 1);
      scan(1, 7'h49,      1'b0, 6, 1);
      scan(2, seg_tab[1], 1'b0, 6, 1);
      scan(3, seg_tab[2], 1'b0, 6, 1);
      wait_frame(start, 20);
      checks++; if (frame_cnt != start + 1) begin errors++; $display("FAIL invalid_count got %0d exp 1", frame_cnt - start); end
      checks++; if (f_digits !== 16'h21E0) begin errors++; $display("FAIL invalid_digits got %h exp 21e0", f_digits); end
      checks++; if (f_err !== 1'b1) begin errors++; $display("FAIL invalid_decode_err got %b exp 1", f_err); end
      start = frame_cnt;
      for (int k = 0; k < 4; k++) scan(k, seg_tab[k+4], 1'b0, 6, 1);
      wait_frame(start, 20);
      checks++; if (f_digits !== 16'h7654) begin errors++; $display("FAIL clean_digits got %h exp 7654", f_digits); end
      checks++; if (f_err !== 1'b0) begin errors++; $display("FAIL clean_decode_err got %b exp 0", f_err); end
   endtask

   task automatic test_collision();
      int start = frame_cnt;
      scan(2, seg_tab[3], 1'b0, 6, 1);
      scan(3, seg_tab[4], 1'b0, 6, 1);
      hold(4'b0011, seg_tab[5], 1'b0, 5);
      hold(4'b0000, 7'h00, 1'b0, 1);
      checks++; if (collision_err !== 1'b1) begin errors++; $display("FAIL collision_set got %b exp 1", collision_err); end
      scan(1, seg_tab[1], 1'b0, 6, 1);
      repeat (2) @(negedge clock);
      checks++; if (frame_cnt != start) begin errors++; $display("FAIL collision_no_commit got %0d exp 0", frame_cnt - start); end
      checks++; if (collision_err !== 1'b1) begin errors++; $display("FAIL collision_sticky got %b exp 1", collision_err); end
      scan(0, seg_tab[2], 1'b0, 6, 1);
      wait_frame(start, 20);
      checks++; if (f_digits !== 16'h4312) begin errors++; $display("FAIL collision_digits got %h exp 4312", f_digits); end
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
      @(negedge clock);
      checks++; if (collision_err !== 1'b0) begin errors++; $display("FAIL collision_clear got %b exp 0", collision_err); end
   endtask

   task automatic test_timeout();
      int start = frame_cnt;
      int n = 0;
      scan(0, seg_tab[1], 1'b0, 6, 1);
      scan(1, seg_tab[2], 1'b0, 6, 1);
      scan(2, seg_tab[3], 1'b0, 6, 1);
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL timeout_early_stale got %b exp 0", stale); end
      while (stale !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      checks++; if (stale !== 1'b1 || n < 10 || n > 18) begin errors++; $display("FAIL timeout_stale got stale=%b after %0d cycles exp 1 after 10..18", stale, n); end
      checks++; if (frame_cnt != start) begin errors++; $display("FAIL timeout_no_frame got %0d exp 0", frame_cnt - start); end
      scan(3, seg_tab[0], 1'b0, 6, 1);
      repeat (2) @(negedge clock);
      checks++; if (frame_cnt != start) begin errors++; $display("FAIL timeout_leftover got %0d exp 0", frame_cnt - start); end
      scan(0, seg_tab[5], 1'b0, 6, 1);
      scan(1, seg_tab[6], 1'b0, 6, 1);
      scan(2, seg_tab[7], 1'b0, 6, 1);
      wait_frame(start, 20);
      checks++; if (frame_cnt != start + 1) begin errors++; $display("FAIL timeout_frame_count got %0d exp 1", frame_cnt - start); end
      checks++; if (f_digits !== 16'h0765) begin errors++; $display("FAIL timeout_digits got %h exp 0765", f_digits); end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL timeout_stale_clear got %b exp 0", stale); end
   endtask

   task automatic test_blank_dot();
      int start = frame_cnt;
      scan(0, seg_tab[9], 1'b0, 6, 1);
      scan(1, seg_tab[8], 1'b0, 6, 1);
      scan(2, seg_tab[7], 1'b0, 6, 1);
      scan(3, 7'h00,      1'b1, 6, 1);
      wait_frame(start, 20);
      checks++; if (f_digits !== 16'h0789) begin errors++; $display("FAIL blank_digits got %h exp 0789", f_digits); end
      checks++; if (f_blank !== 4'b1000) begin errors++; $display("FAIL blank_bits got %b exp 1000", f_blank); end
      checks++; if (f_dot !== 4'b1000) begin errors++; $display("FAIL blank_dot got %b exp 1000", f_dot); end
      checks++; if (f_err !== 1'b0) begin errors++; $display("FAIL blank_decode_err got %b exp 0", f_err); end
   endtask

   task automatic test_reset_mid_frame();
      int start = frame_cnt;
      scan(0, seg_tab[1], 1'b0, 6, 1);
      scan(1, seg_tab[1], 1'b0, 6, 1);
      scan(2, seg_tab[1], 1'b0, 6, 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      checks++; if (digits_out !== 16'h0) begin errors++; $display("FAIL midreset_digits got %h exp 0000", digits_out); end
      scan(3, seg_tab[2], 1'b0, 6, 1);
      repeat (2) @(negedge clock);
      checks++; if (frame_cnt != start) begin errors++; $display("FAIL midreset_no_frame got %0d exp 0", frame_cnt - start); end
      scan(0, seg_tab[3], 1'b0, 6, 1);
      scan(1, seg_tab[4], 1'b0, 6, 1);
      scan(2, seg_tab[5], 1'b0, 6, 1);
      wait_frame(start, 20);
      checks++; if (f_digits !== 16'h2543) begin errors++; $display("FAIL midreset_digits_after got %h exp 2543", f_digits); end
   endtask

   task automatic test_random();
      int ord[4];
      logic [6:0] pat[4];
      logic       dts[4];
      for (int f = 0; f < 20; f++) begin
         int start = frame_cnt;
         logic [15:0] exp_d;
         logic [3:0]  exp_b, exp_dot;
         logic        exp_e;
         logic [15:0] popped;
         for (int k = 0; k < 4; k++) ord[k] = k;
         for (int k = 3; k > 0; k--) begin
            int j = $urandom_range(0, k);
            int t = ord[k];
            ord[k] = ord[j];
            ord[j] = t;
         end
         for (int s = 0; s < 4; s++) begin
            int d = ord[s];
            // occasionally overwrite an already staged digit before the last one
            if (s == 3 && $urandom_range(0, 3) == 0) begin
               int r = ord[0];
               pat[r] = rand_pat();
               dts[r] = 1'($urandom_range(0, 1));
               scan(r, pat[r], dts[r], $urandom_range(SETTLE, 8), $urandom_range(1, 3));
            end
            pat[d] = rand_pat();
            dts[d] = 1'($urandom_range(0, 1));
            scan(d, pat[d], dts[d], $urandom_range(SETTLE, 8), $urandom_range(1, 3));
         end
         exp_e = 1'b0;
         for (int k = 0; k < 4; k++) begin
            exp_d[4*k +: 4] = ref_val(pat[k]);
            exp_b[k]        = (pat[k] == 7'h00);
            exp_dot[k]      = dts[k];
            if (ref_val(pat[k]) == 4'hE) exp_e = 1'b1;
         end
         exp_q.push_back(exp_d);
         wait_frame(start, 20);
         popped = exp_q.pop_front();
         checks++; if (frame_cnt != start + 1) begin errors++; $display("FAIL rand_count frame %0d got %0d exp 1", f, frame_cnt - start); end
         checks++; if (f_digits !== popped) begin errors++; $display("FAIL rand_digits frame %0d got %h exp %h", f, f_digits, popped); end
         checks++; if (f_blank !== exp_b) begin errors++; $display("FAIL rand_blank frame %0d got %b exp %b", f, f_blank, exp_b); end
         checks++; if (f_dot !== exp_dot) begin errors++; $display("FAIL rand_dot frame %0d got %b exp %b", f, f_dot, exp_dot); end
         checks++; if (f_err !== exp_e) begin errors++; $display("FAIL rand_decode_err frame %0d got %b exp %b", f, f_err, exp_e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_settle();
      test_invalid();
      test_collision();
      test_timeout();
      test_blank_dot();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
